// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg
//   Shared definitions for the sequential binary-to-BCD converter:
//   FSM state encoding, legal width range, and the constant functions
//   used for the digit-count check and the bit-counter width.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int MIN_BIN_W = 4;
    localparam int MAX_BIN_W = 32;

    // Number of decimal digits needed for the largest unsigned value of
    // 'width' bits, i.e. ceil(width * log10(2)).
    function automatic int min_digits(input int width);
        longint unsigned v;
        int              d;
        v = (64'd1 << width) - 64'd1;
        d = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                d = d + 1;
                v = v / 64'd10;
            end
        end
        return d;
    endfunction

    // Bit counter must hold the value 'width' itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// bin2bcd_if
//   Start/ready/valid handshake bundle between a requester and bin2bcd_seq.
//   master : requester (drives start_i/bin_i, receives the result)
//   slave  : converter (receives the request, drives ready/valid/bcd/neg)
//   start_i  1          request a conversion
//   bin_i    BIN_W      word to convert
//   ready_o  1          converter idle, start_i will be accepted
//   valid_o  1          one-cycle result strobe
//   bcd_o    4*DIGITS   packed BCD result, units digit in [3:0]
//   neg_o    1          sign of the last result
interface bin2bcd_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start_i;
    logic [BIN_W-1:0]      bin_i;
    logic                  ready_o;
    logic                  valid_o;
    logic [4*DIGITS-1:0]   bcd_o;
    logic                  neg_o;

    modport master (
        output start_i, bin_i,
        input  ready_o, valid_o, bcd_o, neg_o
    );

    modport slave (
        input  start_i, bin_i,
        output ready_o, valid_o, bcd_o, neg_o
    );
endinterface

// File: rtl/bin2bcd_digit_adj.sv
// bcd_digit_adj
//   Combinational double-dabble cell: a BCD digit of 5 or more gets +3 so
//   that the following left shift carries correctly into the next digit.
//   d_i  4  digit before adjustment
//   d_o  4  adjusted digit
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
//   clock. A conversion takes BIN_W+2 cycles from the accepting edge until
//   the next start can be accepted.
//   clk_i  1  clock, rising edge
//   rst_i  1  synchronous active-high reset
//   bus       bin2bcd_if.slave handshake (start_i, bin_i, ready_o, valid_o,
//             bcd_o, neg_o)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | ready_o=1, waiting for start_i; result outputs hold
//   ST_SHIFT | one adjust+shift step per cycle, BIN_W cycles
//   ST_DONE  | publish digits/sign to bcd_o/neg_o, pulse valid_o
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    bin2bcd_if.slave   bus
);

    localparam int CNT_W = cnt_width(BIN_W);
    localparam int BCD_W = 4 * DIGITS;

    generate
        if (BIN_W < MIN_BIN_W || BIN_W > MAX_BIN_W) begin : g_bad_width
            $fatal(1, "bin2bcd_seq: BIN_W=%0d outside %0d..%0d",
                   BIN_W, MIN_BIN_W, MAX_BIN_W);
        end
        if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
            $fatal(1, "bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d (need %0d)",
                   DIGITS, BIN_W, min_digits(BIN_W));
        end
    endgenerate

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   sr_q, sr_d;
    logic [BCD_W-1:0]   dig_q, dig_d;
    logic [BCD_W-1:0]   dig_adj;
    logic               sign_q, sign_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               valid_q, valid_d;

    logic               in_neg;
    logic [BIN_W-1:0]   in_mag;

    // Negating the most negative value wraps back to itself, which read as
    // unsigned is exactly its magnitude 2^(BIN_W-1).
    assign in_neg = (SIGNED != 0) && bus.bin_i[BIN_W-1];
    assign in_mag = in_neg ? (~bus.bin_i + BIN_W'(1)) : bus.bin_i;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (dig_q[4*k +: 4]),
            .d_o (dig_adj[4*k +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        dig_d   = dig_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    sr_d    = in_mag;
                    sign_d  = in_neg;
                    dig_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                dig_d = {dig_adj[BCD_W-2:0], sr_q[BIN_W-1]};
                sr_d  = {sr_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = dig_q;
                // A signed zero is never reported as negative.
                neg_d   = sign_q && (dig_q != '0);
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dig_q   <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dig_q   <= dig_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready_o = (state_q == ST_IDLE);
    assign bus.valid_o = valid_q;
    assign bus.bcd_o   = bcd_q;
    assign bus.neg_o   = neg_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
//   Directed bench for bin2bcd_seq: default 16-bit unsigned, 16-bit signed
//   and 8-bit/3-digit instances sharing one clock and reset.
module tb_bin2bcd_seq;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    bin2bcd_if #(.BIN_W(16), .DIGITS(5)) if_a ();
    bin2bcd_if #(.BIN_W(16), .DIGITS(5)) if_s ();
    bin2bcd_if #(.BIN_W(8),  .DIGITS(3)) if_b ();

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_dut_a (
        .clk_i (clk_i), .rst_i (rst_i), .bus (if_a.slave));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u_dut_s (
        .clk_i (clk_i), .rst_i (rst_i), .bus (if_s.slave));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(0)) u_dut_b (
        .clk_i (clk_i), .rst_i (rst_i), .bus (if_b.slave));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic get_valid(input int sel);
        case (sel)
            0: return if_a.valid_o;
            1: return if_s.valid_o;
            default: return if_b.valid_o;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0: return if_a.ready_o;
            1: return if_s.ready_o;
            default: return if_b.ready_o;
        endcase
    endfunction

    function automatic logic [19:0] get_bcd(input int sel);
        case (sel)
            0: return if_a.bcd_o;
            1: return if_s.bcd_o;
            default: return {8'h00, if_b.bcd_o};
        endcase
    endfunction

    function automatic logic get_neg(input int sel);
        case (sel)
            0: return if_a.neg_o;
            1: return if_s.neg_o;
            default: return if_b.neg_o;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic st, input logic [15:0] bin);
        case (sel)
            0: begin if_a.start_i = st; if_a.bin_i = bin; end
            1: begin if_s.start_i = st; if_s.bin_i = bin; end
            default: begin if_b.start_i = st; if_b.bin_i = bin[7:0]; end
        endcase
    endtask

    // Pulses start for one edge, then waits for valid_o. Latency counts
    // edges from the accepting edge (inclusive) to the valid_o cycle.
    task automatic do_conv(input int sel, input logic [15:0] bin,
                           input logic [19:0] exp_bcd, input logic exp_neg,
                           input int exp_lat, input string tag);
        int lat;
        check({tag, "_ready"}, {31'd0, get_ready(sel)}, 32'd1);
        set_start(sel, 1'b1, bin);
        @(posedge clk_i); #1;
        set_start(sel, 1'b0, 16'h0000);
        lat = 1;
        while (!get_valid(sel) && lat < 60) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_bcd"}, {12'd0, get_bcd(sel)}, {12'd0, exp_bcd});
        check({tag, "_neg"}, {31'd0, get_neg(sel)}, {31'd0, exp_neg});
    endtask

    initial begin
        int nv;
        logic [19:0] got;

        set_start(0, 1'b0, 16'h0000);
        set_start(1, 1'b0, 16'h0000);
        set_start(2, 1'b0, 16'h0000);
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", {31'd0, if_a.ready_o}, 32'd1);
        check("rst_valid", {31'd0, if_a.valid_o}, 32'd0);
        check("rst_bcd",   {12'd0, if_a.bcd_o}, 32'd0);
        check("rst_neg",   {31'd0, if_a.neg_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Unsigned default instance
        do_conv(0, 16'hBABE, 20'h47806, 1'b0, 18, "babe");
        @(posedge clk_i); #1;
        check("babe_pulse_end", {31'd0, if_a.valid_o}, 32'd0);
        check("babe_hold", {12'd0, if_a.bcd_o}, 32'h47806);
        do_conv(0, 16'hFFFF, 20'h65535, 1'b0, 18, "ffff");
        do_conv(0, 16'h0000, 20'h00000, 1'b0, 18, "zero_b2b");

        // Signed instance
        do_conv(1, 16'h8000, 20'h32768, 1'b1, 18, "s_8000");
        do_conv(1, 16'hFFFF, 20'h00001, 1'b1, 18, "s_ffff");
        do_conv(1, 16'h0000, 20'h00000, 1'b0, 18, "s_zero");
        do_conv(1, 16'h7FFF, 20'h32767, 1'b0, 18, "s_7fff");

        // start held high, bin_i changing during SHIFT
        @(posedge clk_i); #1;
        if_a.start_i = 1'b1;
        if_a.bin_i   = 16'hFACE;
        @(posedge clk_i); #1;
        if_a.bin_i   = 16'hBEEF;
        nv  = 0;
        got = 20'h0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk_i); #1;
            if (if_a.valid_o) begin
                nv++;
                got = if_a.bcd_o;
                if_a.start_i = 1'b0;
            end
        end
        if_a.start_i = 1'b0;
        check("held_count", nv, 32'd1);
        check("held_bcd", {12'd0, got}, 32'h64206);

        // Reset in the middle of a conversion
        if_a.start_i = 1'b1;
        if_a.bin_i   = 16'hFEED;
        @(posedge clk_i); #1;
        if_a.start_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        check("shift_hold_bcd", {12'd0, if_a.bcd_o}, 32'h64206);
        check("shift_ready", {31'd0, if_a.ready_o}, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("abort_ready", {31'd0, if_a.ready_o}, 32'd1);
        check("abort_bcd", {12'd0, if_a.bcd_o}, 32'd0);
        nv = 0;
        for (int i = 0; i < 25; i++) begin
            if (if_a.valid_o) nv++;
            @(posedge clk_i); #1;
        end
        check("abort_no_valid", nv, 32'd0);
        do_conv(0, 16'hB00B, 20'h45067, 1'b0, 18, "b00b");

        // 8-bit, 3-digit instance
        do_conv(2, 16'h00FF, 20'h00255, 1'b0, 10, "w8_255");
        do_conv(2, 16'h0064, 20'h00100, 1'b0, 10, "w8_100");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
